dma_pkt_fifo: RTL and testbench
===============================

Name: dma_pkt_fifo

Overview:
- Parametrised store-and-forward successor to the DAQ DMA staging FIFO. Sits between event-builder output and the DMA engine.
- Buffers DATA_W-bit words with a per-word last flag. Presents a first-word-fall-through valid/ready stream.
- PKT_MODE=1: only releases complete packets, and drops a whole packet atomically on overflow. PKT_MODE=0: plain streaming FIFO.
- Reports registered free space, stored packet count and a saturating drop counter.

Parameters:
- DATA_W, 64: payload width; last flag stored alongside (DATA_W+1 bits per entry, block RAM).
- ADDR_W, 9: depth = 2^ADDR_W entries; usable capacity CAP = 2^ADDR_W - 1.
- PKT_MODE, 1: 1 = store-and-forward with packet drop; 0 = streaming, per-word drop.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- din, input, DATA_W: write data.
- din_last, input, 1: marks final word of a packet.
- we, input, 1: write strobe (no backpressure; the writer never stalls).
- dout, output, DATA_W: read data, registered.
- dout_last, output, 1: last flag of dout.
- valid, output, 1: dout/dout_last hold a word.
- ready, input, 1: consumer accepts the word when valid && ready.
- free_space, output, ADDR_W: CAP - (w_ptr - r_ptr), registered, one cycle lag.
- pkt_count, output, ADDR_W: complete packets held (RAM + output register).
- drop_cnt, output, 16: words discarded, saturates at 16'hFFFF.
- overflow, output, 1: sticky; set on first discarded word; cleared only by reset.

Behaviour:
- Reset values:
  - All pointers = 0; write state = IDLE.
  - valid = 0, dout = 0, dout_last = 0.
  - free_space = CAP, pkt_count = 0, drop_cnt = 0, overflow = 0.
- Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
  - w_ptr: working write pointer.
  - w_cmt: committed write pointer.
  - r_ptr: read pointer.
- full = ((w_ptr - r_ptr) == CAP), from current registered pointers. A read in the same cycle does not free space for a simultaneous write; that write is discarded.
- Write-side FSM, PKT_MODE=1:
  - IDLE / IN_PKT, we && !full: store word at w_ptr, w_ptr+1.
    - din_last=1: w_cmt <= w_ptr+1 and pkt_count+1; go to IDLE.
    - din_last=0: go to IN_PKT.
  - IDLE / IN_PKT, we && full: discard word, w_ptr <= w_cmt (rewind the partial packet), drop_cnt+1, overflow=1.
    - din_last=1: go to IDLE.
    - din_last=0: go to DROPPING.
  - DROPPING, we: discard word, drop_cnt+1; din_last=1 -> IDLE. Full is ignored in DROPPING.
  - A packet longer than CAP is always dropped entirely.
  - Rewound words are not included in drop_cnt; only discarded input words count.
- PKT_MODE=0:
  - w_cmt tracks w_ptr every write; the FSM stays IDLE.
  - A full write discards that word only (drop_cnt+1, overflow=1).
  - pkt_count still counts last-flagged words.
- Read side:
  - Readable words = w_cmt - r_ptr.
  - The output register loads from RAM when it is empty, or when it is being consumed (valid && ready) and a readable word exists.
  - RAM read address uses next r_ptr, giving FWFT.
- Latency, empty FIFO:
  - valid rises exactly 2 clocks after the edge that commits the word. In PKT_MODE=1 that edge is the one writing the last word.
  - Back-to-back reads sustain one word per clock while readable words remain.
- valid && !ready: dout, dout_last and valid hold stable.
- Transfer with dout_last=1 decrements pkt_count. A commit and a last-transfer in the same cycle leave it unchanged.
- free_space counts uncommitted and output-register words as occupied.
- Reset mid-packet or mid-drop: all content discarded, state IDLE. The first word after reset starts a new packet.

Test Plan:
- Reset, write 1 packet of 4 words (last on word 3), ready=1 -> valid high 2 clocks after the last-word write edge. 4 consecutive transfers, dout_last only on the 4th. pkt_count 1->0, free_space returns to 511.
- PKT_MODE=1, write 3 words without last, ready=1 -> valid stays 0. free_space=508 (after one-cycle lag), pkt_count=0.
- Fill CAP=511 words as one packet with last, ready=0 -> free_space=0. A 2nd packet of 3 words: all discarded, drop_cnt=3, overflow=1. After draining, pkt_count=0.
- Store a 500-word packet, then a 20-word packet with ready=0 -> 2nd packet overflows at word 12. w_ptr rewinds to the 500-word boundary, DROPPING until last, drop_cnt=9. The first packet is read out intact.
- ready toggling 1/0 each clock across pointer wrap (write 1200 words in 10 packets) -> data order preserved, no duplicates or losses, dout stable while ready=0.
- Assert reset while in DROPPING with 2 packets stored -> next cycle valid=0, pkt_count=0, free_space=511, drop_cnt=0, overflow=0. A new packet then passes normally.

Source files
------------

// File: rtl/dma_pkt_fifo.sv
// dma_pkt_fifo: store-and-forward packet FIFO between the event builder and
// the DMA engine. Words carry a last flag; in packet mode only complete
// packets become readable and an overflowing packet is dropped as a whole.
//
// Output handshake: valid means dout/dout_last hold a word; the word is taken
// on a clock edge where valid && ready. While valid && !ready the outputs hold.
module dma_pkt_fifo #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 9,
    parameter int PKT_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    input  logic              we,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W-1:0] free_space,
    output logic [ADDR_W-1:0] pkt_count,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CAP = '1;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IN_PKT   = 2'd1;
    localparam logic [1:0] DROPPING = 2'd2;

    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   ram_q;

    // w_ptr: working write pointer; w_cmt: end of the last complete packet.
    // rd_ptr: next RAM word to move into the output register.
    // r_ptr: retire pointer, advances only when the consumer takes a word, so
    // the word sitting in the output register still counts as occupied.
    logic [ADDR_W-1:0] w_ptr, w_cmt, w_cmt_q, rd_ptr, r_ptr, rd_ptr_next, used;
    logic [1:0]        state;
    logic              full, store, drop, commit, load, xfer, pkt_inc, pkt_dec;

    // Datapath decisions derived from the current registered pointers.
    always_comb begin
        used        = w_ptr - r_ptr;
        full        = (used == CAP);
        store       = we && !full && (state != DROPPING);
        drop        = we && !store;
        commit      = store && ((PKT_MODE == 0) || din_last);
        pkt_inc     = store && din_last;
        xfer        = valid && ready;
        pkt_dec     = xfer && dout_last;
        // w_cmt_q lags w_cmt by one clock so the RAM read of a freshly
        // committed word has completed before the output register takes it.
        load        = (rd_ptr != w_cmt_q) && (!valid || ready);
        rd_ptr_next = load ? rd_ptr + ONE : rd_ptr;
    end

    // RAM write port: accepted words only.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[w_ptr] <= {din_last, din};
        end
    end

    // RAM read port: addressed by the next read pointer for first-word fall-through.
    always_ff @(posedge clk) begin
        ram_q <= mem[rd_ptr_next];
    end

    // Write-side FSM: store, commit on last, rewind and drop on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            w_ptr <= '0;
            w_cmt <= '0;
        end else if (store) begin
            w_ptr <= w_ptr + ONE;
            if (commit) begin
                w_cmt <= w_ptr + ONE;
            end
            if (PKT_MODE != 0) begin
                state <= din_last ? IDLE : IN_PKT;
            end
        end else if (drop) begin
            if (PKT_MODE != 0) begin
                // The partial packet is discarded by rewinding; once in
                // DROPPING the pointer already sits on the commit boundary.
                if (state != DROPPING) begin
                    w_ptr <= w_cmt;
                end
                state <= din_last ? IDLE : DROPPING;
            end
        end
    end

    // Read side: output register, fetch and retire pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_cmt_q   <= '0;
            rd_ptr    <= '0;
            r_ptr     <= '0;
            valid     <= 1'b0;
            dout      <= '0;
            dout_last <= 1'b0;
        end else begin
            w_cmt_q <= w_cmt;
            rd_ptr  <= rd_ptr_next;
            if (xfer) begin
                r_ptr <= r_ptr + ONE;
            end
            if (load) begin
                valid                <= 1'b1;
                {dout_last, dout}    <= ram_q;
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

    // Status: free space (one clock behind the pointers), packet count, drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_space <= CAP;
            pkt_count  <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            free_space <= CAP - used;
            if (pkt_inc && !pkt_dec) begin
                pkt_count <= pkt_count + ONE;
            end else if (!pkt_inc && pkt_dec) begin
                pkt_count <= pkt_count - ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_pkt_fifo.sv
// Testbench for dma_pkt_fifo (DATA_W=64, ADDR_W=9, PKT_MODE=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dma_pkt_fifo;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_last = 1'b0;
    logic              we = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_last;
    logic              valid;
    logic              ready = 1'b0;
    logic [ADDR_W-1:0] free_space;
    logic [ADDR_W-1:0] pkt_count;
    logic [15:0]       drop_cnt;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];

    dma_pkt_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_MODE(1)) dut (
        .clk(clk), .reset(reset), .din(din), .din_last(din_last), .we(we),
        .dout(dout), .dout_last(dout_last), .valid(valid), .ready(ready),
        .free_space(free_space), .pkt_count(pkt_count),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    // Clock and run-time guard.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] pat(input int p, input int i);
        return {p[15:0], 16'hC3A5, i[15:0], 16'h5A3C};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; ready = 1'b0; din = '0; din_last = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d, input logic l, input bit keep);
        din = d; din_last = l; we = 1'b1;
        if (keep) exp_q.push_back({l, d});
        step();
        we = 1'b0; din_last = 1'b0;
    endtask

    // Reads words until exp_q is empty or the cycle budget runs out; reports
    // words taken, data mismatches and hold violations while ready was low.
    task automatic drain(input int max_cycles, input bit toggle,
                         output int n_words, output int n_bad, output int n_hold_bad);
        logic [DATA_W:0] held;
        logic [DATA_W:0] obs;
        bit held_v;
        bit r;
        n_words = 0; n_bad = 0; n_hold_bad = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) begin
            r = toggle ? (c % 2 == 0) : 1'b1;
            obs = {dout_last, dout};
            if (held_v && (!valid || obs !== held)) n_hold_bad++;
            held_v = 1'b0;
            if (valid) begin
                if (obs !== exp_q[0]) n_bad++;
                if (r) begin
                    exp_q.delete(0);
                    n_words++;
                end else begin
                    held = obs;
                    held_v = 1'b1;
                end
            end
            ready = r;
            step();
        end
        ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last: got %0b want 0", dout_last); end
        checks++; if (free_space !== 9'd511) begin errors++; $display("FAIL reset_free: got %0d want 511", free_space); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL reset_pkt: got %0d want 0", pkt_count); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    endtask

    task automatic test_single_packet();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(pat(1, i), i == 3, 1'b0);
        // Now just after the edge that wrote the last word.
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sp_valid_e0: got %0b want 0", valid); end
        checks++; if (pkt_count !== 9'd1) begin errors++; $display("FAIL sp_pkt_one: got %0d want 1", pkt_count); end
        checks++; if (free_space !== 9'd508) begin errors++; $display("FAIL sp_free_508: got %0d want 508", free_space); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sp_valid_e1: got %0b want 0", valid); end
        checks++; if (free_space !== 9'd507) begin errors++; $display("FAIL sp_free_507: got %0d want 507", free_space); end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sp_valid_w%0d: got %0b want 1", i, valid); end
            checks++; if (dout !== pat(1, i)) begin errors++; $display("FAIL sp_data_w%0d: got %h want %h", i, dout, pat(1, i)); end
            checks++; if (dout_last !== (i == 3)) begin errors++; $display("FAIL sp_last_w%0d: got %0b want %0b", i, dout_last, i == 3); end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sp_valid_end: got %0b want 0", valid); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL sp_pkt_zero: got %0d want 0", pkt_count); end
        step();
        checks++; if (free_space !== 9'd511) begin errors++; $display("FAIL sp_free_back: got %0d want 511", free_space); end
        ready = 1'b0;
    endtask

    task automatic test_partial_packet();
        bit saw_valid;
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) write_word(pat(2, i), 1'b0, 1'b0);
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (valid) saw_valid = 1'b1;
            step();
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL pp_valid: got 1 want 0"); end
        checks++; if (free_space !== 9'd508) begin errors++; $display("FAIL pp_free: got %0d want 508", free_space); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL pp_pkt: got %0d want 0", pkt_count); end
        ready = 1'b0;
    endtask

    task automatic test_full_drop();
        int n, bad, hbad;
        do_reset();
        for (int i = 0; i < 511; i++) write_word(pat(3, i), i == 510, 1'b1);
        step();
        checks++; if (free_space !== 9'd0) begin errors++; $display("FAIL fd_free: got %0d want 0", free_space); end
        step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fd_valid: got %0b want 1", valid); end
        for (int i = 0; i < 3; i++) write_word(pat(4, i), i == 2, 1'b0);
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL fd_drop: got %0d want 3", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fd_ovf: got %0b want 1", overflow); end
        checks++; if (pkt_count !== 9'd1) begin errors++; $display("FAIL fd_pkt_one: got %0d want 1", pkt_count); end
        drain(700, 1'b0, n, bad, hbad);
        checks++; if (n != 511) begin errors++; $display("FAIL fd_words: got %0d want 511", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL fd_data: got %0d bad words want 0", bad); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL fd_pkt_zero: got %0d want 0", pkt_count); end
    endtask

    task automatic test_overflow_rewind();
        int n, bad, hbad;
        do_reset();
        for (int i = 0; i < 500; i++) write_word(pat(5, i), i == 499, 1'b1);
        for (int i = 0; i < 20; i++) write_word(pat(6, i), i == 19, 1'b0);
        step();
        checks++; if (drop_cnt !== 16'd9) begin errors++; $display("FAIL ov_drop: got %0d want 9", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_ovf: got %0b want 1", overflow); end
        checks++; if (pkt_count !== 9'd1) begin errors++; $display("FAIL ov_pkt: got %0d want 1", pkt_count); end
        checks++; if (free_space !== 9'd11) begin errors++; $display("FAIL ov_free: got %0d want 11", free_space); end
        drain(700, 1'b0, n, bad, hbad);
        checks++; if (n != 500) begin errors++; $display("FAIL ov_words: got %0d want 500", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL ov_data: got %0d bad words want 0", bad); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ov_left: got %0d queued want 0", exp_q.size()); end
    endtask

    task automatic test_wrap_toggle();
        int n, bad, hbad, tot_n, tot_bad, tot_hbad;
        do_reset();
        tot_n = 0; tot_bad = 0; tot_hbad = 0;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 120; i++) write_word(pat(16 + p, i), i == 119, 1'b1);
            drain(300, 1'b1, n, bad, hbad);
            tot_n += n; tot_bad += bad; tot_hbad += hbad;
        end
        checks++; if (tot_n != 1200) begin errors++; $display("FAIL wr_words: got %0d want 1200", tot_n); end
        checks++; if (tot_bad != 0) begin errors++; $display("FAIL wr_data: got %0d bad words want 0", tot_bad); end
        checks++; if (tot_hbad != 0) begin errors++; $display("FAIL wr_hold: got %0d hold violations want 0", tot_hbad); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL wr_pkt: got %0d want 0", pkt_count); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL wr_drop: got %0d want 0", drop_cnt); end
    endtask

    // Last word of one packet leaves on the same edge that commits the next.
    task automatic test_back_to_back();
        int n, bad, hbad;
        do_reset();
        ready = 1'b1;
        write_word(pat(7, 0), 1'b0, 1'b0);
        write_word(pat(7, 1), 1'b1, 1'b0);
        step();
        step();
        checks++; if (valid !== 1'b1 || dout !== pat(7, 0)) begin errors++; $display("FAIL bb_a0: got valid=%0b %h want 1 %h", valid, dout, pat(7, 0)); end
        step();
        checks++; if (dout !== pat(7, 1) || dout_last !== 1'b1) begin errors++; $display("FAIL bb_a1: got %h last=%0b want %h 1", dout, dout_last, pat(7, 1)); end
        write_word(pat(8, 0), 1'b1, 1'b1);
        checks++; if (pkt_count !== 9'd1) begin errors++; $display("FAIL bb_pkt_same: got %0d want 1", pkt_count); end
        drain(20, 1'b0, n, bad, hbad);
        checks++; if (n != 1 || bad != 0) begin errors++; $display("FAIL bb_b: got %0d words %0d bad want 1 0", n, bad); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL bb_pkt_end: got %0d want 0", pkt_count); end
    endtask

    task automatic test_reset_in_drop();
        int n, bad, hbad;
        do_reset();
        for (int i = 0; i < 8; i++) write_word(pat(9, i), (i % 4) == 3, 1'b0);
        for (int i = 0; i < 506; i++) write_word(pat(10, i), 1'b0, 1'b0);
        checks++; if (pkt_count !== 9'd2) begin errors++; $display("FAIL rd_pkt_before: got %0d want 2", pkt_count); end
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL rd_drop_before: got %0d want 3", drop_cnt); end
        do_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rd_valid: got %0b want 0", valid); end
        checks++; if (pkt_count !== 9'd0) begin errors++; $display("FAIL rd_pkt: got %0d want 0", pkt_count); end
        checks++; if (free_space !== 9'd511) begin errors++; $display("FAIL rd_free: got %0d want 511", free_space); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rd_drop: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rd_ovf: got %0b want 0", overflow); end
        for (int i = 0; i < 3; i++) write_word(pat(11, i), i == 2, 1'b1);
        drain(20, 1'b0, n, bad, hbad);
        checks++; if (n != 3 || bad != 0) begin errors++; $display("FAIL rd_newpkt: got %0d words %0d bad want 3 0", n, bad); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rd_newdrop: got %0d want 0", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_partial_packet();
        test_full_drop();
        test_overflow_rewind();
        test_wrap_toggle();
        test_back_to_back();
        test_reset_in_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
